motion_detector: RTL
====================

# motion_detector

Consumer stage for the accelerometer front end. It paces sample requests with `fetch` and waits for `arrived`. It then captures the 32-bit sum-of-squares magnitude `acc`, tracks a slow gravity baseline, and raises a latched `alarm` once the deviation from baseline exceeds a programmable threshold on `HITS` consecutive samples. It sits between the accelerometer reader and the alarm/siren control logic.

## Interface
- `SAMPLE_DIV`, default 1000000: clock cycles between sample requests (100 Hz at 100 MHz); minimum 4.
- `HITS`, default 4: consecutive over-threshold samples required to set `alarm`; range 1..15.
- `BASE_SHIFT`, default 4: baseline IIR shift (weight 2^-BASE_SHIFT).
- `TIMEOUT`, default 65535: cycles to wait for `arrived` before declaring a fault.
- `Clock` in 1: single clock.
- `Reset` in 1: synchronous, active-high reset.
- `arm` in 1: level; 0 holds the block idle and clears alarm state.
- `clear` in 1: pulse; clears `alarm`, `fault` and the hit counter.
- `threshold` in 32: unsigned deviation limit, sampled in S_EVAL.
- `ready` in 1: upstream idle, can accept `fetch`.
- `fetch` out 1: one-cycle sample request.
- `arrived` in 1: one-cycle pulse; upstream `acc` is final the following cycle.
- `acc` in 32: unsigned magnitude from upstream.
- `alarm` out 1: latched motion alarm.
- `fault` out 1: sticky; set when `arrived` does not come within `TIMEOUT` cycles.
- `sample_valid` out 1: one-cycle pulse when `magnitude` and `alarm` are updated.
- `magnitude` out 32: last |sample − baseline|.

## Operation
- States: S_IDLE, S_WAIT, S_FETCH, S_BUSY, S_CAPT, S_EVAL.
- S_IDLE: entered on `arm`=0. Clears `alarm`, the hit counter and `base_valid`. Goes to S_WAIT when `arm`=1.
- S_WAIT: period counter runs 0..SAMPLE_DIV−1, then goes to S_FETCH.
- S_FETCH: waits with no limit for `ready`=1, then registers `fetch`<=1 and goes to S_BUSY.
- S_BUSY: `fetch` is high only in its first cycle. On `arrived`, go to S_CAPT. If the timeout counter reaches TIMEOUT−1 first, set `fault` and go to S_WAIT.
- S_CAPT: `sample`<=`acc`, go to S_EVAL.
- S_EVAL, first sample after arm (`base_valid`=0): `baseline`<=`sample`, set `base_valid`, no evaluation.
- S_EVAL, otherwise:
  - `delta` = |sample − baseline|, 32-bit unsigned via a 33-bit difference.
  - hit = `delta` > `threshold` (strict).
  - On hit: hit counter increments, saturating at HITS; `alarm` sets when the counter reaches HITS; baseline is frozen.
  - On no hit: hit counter resets to 0; `baseline` <= baseline + ((sample − baseline) >>> BASE_SHIFT), using 33-bit signed arithmetic truncated to 32 bits.
  - In both cases `magnitude`<=`delta`, and the state returns to S_WAIT.
- `alarm` stays set until `clear` or `arm`=0. A no-hit sample does not clear it.
- `clear` has priority over an alarm set in the same cycle. Clear always wins.
- `clear` does not reset `baseline` or the FSM.
- `arm` falling in any state goes to S_IDLE next cycle. An in-flight upstream transfer completes unobserved.

## Timing
- Reset values:
  - `fetch`, `alarm`, `fault`, `sample_valid` = 0.
  - `magnitude` = 0.
  - Baseline = 0, `base_valid` = 0.
  - State = S_IDLE.
- `fetch` is asserted only in a cycle where upstream `ready` was high the cycle before.
- Capture timing: `arrived` high in cycle t; `acc` is sampled at the end of cycle t+1 (S_CAPT).
- Output timing: S_EVAL occupies cycle t+2; `sample_valid`, `magnitude` and `alarm` are visible in cycle t+3.
- `sample_valid` does not pulse on the baseline-initialising sample.
- Request period: one `fetch` per SAMPLE_DIV + (S_FETCH wait) + (S_BUSY length) + 2 cycles.
- Reset mid-transfer: all state returns to reset values next cycle. Upstream `arrived` pulses are ignored outside S_BUSY.

## Structure
- Shared package `motion_pkg`: state encoding constants S_IDLE..S_EVAL (3 bits) and the default parameter values.
- One natural sub-module, `motion_timer`: a loadable down-counter shared by the period and timeout functions; only one is active at a time.

## Test plan
- **Init:** SAMPLE_DIV=16, `arm`=1, upstream model returns acc=1000.
  - First `arrived` sets baseline 1000 with no `sample_valid`.
  - Subsequent samples give `magnitude`=0 and `alarm` stays 0.
  - `fetch` spacing is ≥16 cycles.
- **Alarm:** baseline 1000, threshold 500, HITS=4; upstream returns 1600 four times.
  - `alarm` rises in the `sample_valid` cycle of the 4th sample; `magnitude`=600.
  - Baseline stays 1000.
- **Boundary and counter reset:** samples 1500, 1500, 1000, 1500 with threshold 500.
  - Delta 500 is not a hit.
  - Samples 1600, 1600, 1000, 1600, 1600, 1600 produce no alarm until the 4th consecutive hit.
- **Baseline tracking:** baseline 1000, BASE_SHIFT=4, sample 1160 with threshold 500.
  - Baseline becomes 1010; next sample 1160 gives `magnitude`=150.
- **Timeout:** upstream never pulses `arrived`, TIMEOUT=32.
  - `fault`=1 after 32 cycles in S_BUSY and the FSM returns to S_WAIT.
  - `clear` drops `fault` next cycle.
- **Priority and reset:**
  - `clear` asserted in the same cycle `alarm` would set → `alarm` stays 0.
  - `Reset` pulsed during S_BUSY → all outputs 0 next cycle, S_IDLE.

Source files
------------

// File: rtl/motion_pkg.sv
// Shared definitions for the motion detector: FSM state encoding, parameter defaults
// and the unsigned absolute-difference helper used by the evaluator.
package motion_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WAIT  = 3'd1,
    S_FETCH = 3'd2,
    S_BUSY  = 3'd3,
    S_CAPT  = 3'd4,
    S_EVAL  = 3'd5
  } state_e;

  localparam int unsigned DEF_SAMPLE_DIV = 1000000;
  localparam int unsigned DEF_HITS       = 4;
  localparam int unsigned DEF_BASE_SHIFT = 4;
  localparam int unsigned DEF_TIMEOUT    = 65535;
  localparam int unsigned TIMER_W        = 32;

  // |a - b| for 32-bit unsigned operands, given their 33-bit difference.
  function automatic logic [31:0] abs_diff(input logic [32:0] diff);
    return diff[32] ? 32'(-diff) : diff[31:0];
  endfunction

endpackage

// File: rtl/motion_detector_if.sv
// Bundle of the motion detector's control, upstream request/response and result signals.
interface motion_detector_if;
  logic        arm;
  logic        clear;
  logic [31:0] threshold;
  logic        ready;
  logic        fetch;
  logic        arrived;
  logic [31:0] acc;
  logic        alarm;
  logic        fault;
  logic        sample_valid;
  logic [31:0] magnitude;

  modport master (
    input  arm, clear, threshold, ready, arrived, acc,
    output fetch, alarm, fault, sample_valid, magnitude
  );

  modport slave (
    output arm, clear, threshold, ready, arrived, acc,
    input  fetch, alarm, fault, sample_valid, magnitude
  );
endinterface

// File: rtl/motion_timer.sv
// Loadable down-counter shared by the sample-period and response-timeout functions.
module motion_timer #(
  parameter int unsigned W = 32
) (
  input  logic         Clock,
  input  logic         Reset,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    // NOTE: default every combinational output first so no path can infer a latch.
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (dec && count_q != '0) begin
      count_d = count_q - 1'b1;
    end
  end

  // NOTE: state flops use non-blocking assignments so all registers update together.
  always_ff @(posedge Clock) begin
    if (Reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/motion_detector.sv
// Paces accelerometer sample requests, tracks a gravity baseline and latches an alarm
// after HITS consecutive samples deviate from the baseline by more than the threshold.
module motion_detector
  import motion_pkg::*;
#(
  parameter int unsigned SAMPLE_DIV = DEF_SAMPLE_DIV,
  parameter int unsigned HITS       = DEF_HITS,
  parameter int unsigned BASE_SHIFT = DEF_BASE_SHIFT,
  parameter int unsigned TIMEOUT    = DEF_TIMEOUT
) (
  input logic               Clock,
  input logic               Reset,
  motion_detector_if.master bus
);

  localparam logic [TIMER_W-1:0] PERIOD_LOAD  = TIMER_W'(SAMPLE_DIV - 1);
  localparam logic [TIMER_W-1:0] TIMEOUT_LOAD = TIMER_W'(TIMEOUT - 1);
  localparam logic [3:0]         HITS_L       = 4'(HITS);

  state_e              state_q, state_d;
  logic                tmr_load, tmr_dec, tmr_zero;
  logic [TIMER_W-1:0]  tmr_val;

  logic                fetch_q, fetch_d;
  logic                sample_valid_q, sample_valid_d;
  logic                alarm_q, alarm_d;
  logic                fault_q, fault_d;
  logic                base_valid_q, base_valid_d;
  logic [3:0]          hit_cnt_q, hit_cnt_d;
  logic [31:0]         sample_q, sample_d;
  logic [31:0]         baseline_q, baseline_d;
  logic [31:0]         magnitude_q, magnitude_d;

  logic [32:0]         diff;
  logic signed [32:0]  step;
  logic [31:0]         delta;
  logic                hit;

  motion_timer #(.W(TIMER_W)) u_timer (
    .Clock    (Clock),
    .Reset    (Reset),
    .load     (tmr_load),
    .dec      (tmr_dec),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  always_ff @(posedge Clock) begin
    if (Reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // The timer is reloaded on every entry to S_WAIT or S_BUSY, so each wait starts fresh.
  always_comb begin
    state_d  = state_q;
    tmr_load = 1'b0;
    tmr_dec  = 1'b0;
    tmr_val  = PERIOD_LOAD;
    if (!bus.arm) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d  = S_WAIT;
          tmr_load = 1'b1;
        end
        S_WAIT: begin
          if (tmr_zero) state_d = S_FETCH;
          else          tmr_dec = 1'b1;
        end
        S_FETCH: begin
          if (bus.ready) begin
            state_d  = S_BUSY;
            tmr_load = 1'b1;
            tmr_val  = TIMEOUT_LOAD;
          end
        end
        S_BUSY: begin
          if (bus.arrived) begin
            state_d = S_CAPT;
          end else if (tmr_zero) begin
            state_d  = S_WAIT;
            tmr_load = 1'b1;
          end else begin
            tmr_dec = 1'b1;
          end
        end
        S_CAPT: state_d = S_EVAL;
        S_EVAL: begin
          state_d  = S_WAIT;
          tmr_load = 1'b1;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    fetch_d        = 1'b0;
    sample_valid_d = 1'b0;
    alarm_d        = alarm_q;
    fault_d        = fault_q;
    base_valid_d   = base_valid_q;
    hit_cnt_d      = hit_cnt_q;
    sample_d       = sample_q;
    baseline_d     = baseline_q;
    magnitude_d    = magnitude_q;
    diff           = {1'b0, sample_q} - {1'b0, baseline_q};
    step           = $signed(diff) >>> BASE_SHIFT;
    delta          = abs_diff(diff);
    hit            = delta > bus.threshold;

    if (!bus.arm || state_q == S_IDLE) begin
      alarm_d      = 1'b0;
      hit_cnt_d    = '0;
      base_valid_d = 1'b0;
    end else begin
      case (state_q)
        S_FETCH: fetch_d = bus.ready;
        S_BUSY:  if (!bus.arrived && tmr_zero) fault_d = 1'b1;
        S_CAPT:  sample_d = bus.acc;
        S_EVAL: begin
          if (!base_valid_q) begin
            baseline_d   = sample_q;
            base_valid_d = 1'b1;
          end else begin
            sample_valid_d = 1'b1;
            magnitude_d    = delta;
            if (hit) begin
              // Baseline is frozen while motion is being seen.
              hit_cnt_d = (hit_cnt_q >= HITS_L) ? HITS_L : hit_cnt_q + 4'd1;
              if (hit_cnt_d == HITS_L) alarm_d = 1'b1;
            end else begin
              hit_cnt_d  = '0;
              baseline_d = baseline_q + 32'(step);
            end
          end
        end
        default: ;
      endcase
    end

    if (bus.clear) begin
      alarm_d   = 1'b0;
      fault_d   = 1'b0;
      hit_cnt_d = '0;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      fetch_q        <= 1'b0;
      sample_valid_q <= 1'b0;
      alarm_q        <= 1'b0;
      fault_q        <= 1'b0;
      base_valid_q   <= 1'b0;
      hit_cnt_q      <= '0;
      sample_q       <= '0;
      baseline_q     <= '0;
      magnitude_q    <= '0;
    end else begin
      fetch_q        <= fetch_d;
      sample_valid_q <= sample_valid_d;
      alarm_q        <= alarm_d;
      fault_q        <= fault_d;
      base_valid_q   <= base_valid_d;
      hit_cnt_q      <= hit_cnt_d;
      sample_q       <= sample_d;
      baseline_q     <= baseline_d;
      magnitude_q    <= magnitude_d;
    end
  end

  assign bus.fetch        = fetch_q;
  assign bus.sample_valid = sample_valid_q;
  assign bus.alarm        = alarm_q;
  assign bus.fault        = fault_q;
  assign bus.magnitude    = magnitude_q;

endmodule
